// File: rtl/fb_swap_ctrl_if.sv
// Writer/scanner-side handshake bundle for the frame-buffer double-buffer swap controller.
// master = the side issuing requests and frame pulses, slave = the controller.
interface fb_swap_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             swap_req;
    logic             frame_done;
    logic             overrun_clr;
    logic             bank_sel;
    logic             writer_en;
    logic             swap_ack;
    logic             swap_pending;
    logic             swap_overrun;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output swap_req,
        output frame_done,
        output overrun_clr,
        input  bank_sel,
        input  writer_en,
        input  swap_ack,
        input  swap_pending,
        input  swap_overrun,
        input  frame_count
    );

    modport slave (
        input  swap_req,
        input  frame_done,
        input  overrun_clr,
        output bank_sel,
        output writer_en,
        output swap_ack,
        output swap_pending,
        output swap_overrun,
        output frame_count
    );
endinterface

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller: flips the displayed bank on a frame boundary after a writer
// request, then blocks writes for a guard window before acknowledging the new back buffer.
module fb_swap_ctrl #(
    parameter int unsigned MIN_FRAMES   = 1,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input logic           clk,
    input logic           reset_n,
    fb_swap_ctrl_if.slave bus
);

    localparam int unsigned ShownW = $clog2(MIN_FRAMES + 1);
    localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [ShownW:0]   MinFrames = MIN_FRAMES[ShownW:0];
    localparam logic [GuardW-1:0] GuardInit = GuardW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPending, StGuard, StAck} state_e;

    state_e             state_q, state_d;
    logic               bank_q, bank_d;
    logic               wen_q, wen_d;
    logic               ack_q, ack_d;
    logic               pend_q, pend_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ShownW-1:0]  shown_q, shown_d;
    logic [GuardW-1:0]  guard_q, guard_d;

    logic [ShownW:0]    shown_inc;
    logic               shown_full;
    logic               swap_go;

    // The current frame_done pulse counts toward the minimum display time.
    assign shown_inc  = {1'b0, shown_q} + 1'b1;
    assign shown_full = (shown_inc >= MinFrames);
    assign swap_go    = (state_q == StPending) && bus.frame_done && shown_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            bank_q  <= 1'b0;
            wen_q   <= 1'b1;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            shown_q <= '0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            wen_q   <= wen_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            shown_q <= shown_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.swap_req) state_d = StPending;
            StPending: if (swap_go) state_d = StGuard;
            StGuard:   if (guard_q == '0) state_d = StAck;
            StAck:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bank_d  = bank_q ^ swap_go;
        wen_d   = (state_d != StGuard);
        ack_d   = (state_d == StAck);
        pend_d  = (state_d == StPending);
        cnt_d   = cnt_q + CNT_W'(bus.frame_done);

        // A request outside IDLE is dropped; flagging it takes priority over the clear.
        ovr_d = ovr_q;
        if (bus.swap_req && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end else if (bus.overrun_clr) begin
            ovr_d = 1'b0;
        end

        shown_d = shown_q;
        if (swap_go) begin
            shown_d = '0;
        end else if (bus.frame_done) begin
            shown_d = shown_full ? MinFrames[ShownW-1:0] : shown_inc[ShownW-1:0];
        end

        guard_d = guard_q;
        if (swap_go) begin
            guard_d = GuardInit;
        end else if ((state_q == StGuard) && (guard_q != '0)) begin
            guard_d = guard_q - 1'b1;
        end
    end

    assign bus.bank_sel     = bank_q;
    assign bus.writer_en    = wen_q;
    assign bus.swap_ack     = ack_q;
    assign bus.swap_pending = pend_q;
    assign bus.swap_overrun = ovr_q;
    assign bus.frame_count  = cnt_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: two instances (MIN_FRAMES=1/GUARD=4 and MIN_FRAMES=3/GUARD=2) share
// stimulus; a timestamp-based reference model, a vector table and directed sequences check them.
module tb_fb_swap_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_v = 1'b0;
    logic fd_v = 1'b0;
    logic clr_v = 1'b0;

    always #5 clk = ~clk;

    fb_swap_ctrl_if #(.CNT_W(16)) bus_a ();
    fb_swap_ctrl_if #(.CNT_W(16)) bus_b ();

    assign bus_a.swap_req    = req_v;
    assign bus_a.frame_done  = fd_v;
    assign bus_a.overrun_clr = clr_v;
    assign bus_b.swap_req    = req_v;
    assign bus_b.frame_done  = fd_v;
    assign bus_b.overrun_clr = clr_v;

    fb_swap_ctrl #(.MIN_FRAMES(1), .GUARD_CYCLES(4), .CNT_W(16)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    fb_swap_ctrl #(.MIN_FRAMES(3), .GUARD_CYCLES(2), .CNT_W(16)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: a swap is remembered by the cycle it happened at; guard and ack
    // windows are plain arithmetic on that timestamp.
    int minf[2] = '{1, 3};
    int grd[2]  = '{4, 2};
    bit m_pend[2];
    bit m_bank[2];
    bit m_ovr[2];
    int m_shown[2];
    int m_swap_t[2];
    int m_frames[2];
    int cyc = 0;

    typedef struct {
        logic       req;
        logic       fd;
        logic       clr;
        logic [4:0] exp;  // {bank_sel, writer_en, swap_ack, swap_pending, swap_overrun}
    } vec_t;
    vec_t tbl[$];

    function automatic bit busy(int k, int t);
        return m_swap_t[k] >= 0 && t > m_swap_t[k] && t <= m_swap_t[k] + grd[k] + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]   = 1'b0;
            m_bank[k]   = 1'b0;
            m_ovr[k]    = 1'b0;
            m_shown[k]  = 0;
            m_swap_t[k] = -1;
            m_frames[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit idle;
            bit go;
            idle = !m_pend[k] && !busy(k, cyc);
            go   = m_pend[k] && fd_v && (m_shown[k] + 1 >= minf[k]);
            if (req_v && !idle) m_ovr[k] = 1'b1;
            else if (clr_v) m_ovr[k] = 1'b0;
            if (fd_v) begin
                m_frames[k] = (m_frames[k] + 1) % 65536;
                if (go) m_shown[k] = 0;
                else m_shown[k] = (m_shown[k] + 1 > minf[k]) ? minf[k] : m_shown[k] + 1;
            end
            if (go) begin
                m_bank[k]   = !m_bank[k];
                m_pend[k]   = 1'b0;
                m_swap_t[k] = cyc;
            end else if (req_v && idle) begin
                m_pend[k] = 1'b1;
            end
        end
        cyc++;
    endtask

    function automatic logic [20:0] model_out(int k);
        logic we;
        logic ack;
        we  = !(m_swap_t[k] >= 0 && cyc > m_swap_t[k] && cyc <= m_swap_t[k] + grd[k]);
        ack = m_swap_t[k] >= 0 && cyc == m_swap_t[k] + grd[k] + 1;
        return {m_bank[k], we, ack, m_pend[k], m_ovr[k], 16'(m_frames[k])};
    endfunction

    function automatic logic [20:0] dut_out(int k);
        if (k == 0)
            return {bus_a.bank_sel, bus_a.writer_en, bus_a.swap_ack, bus_a.swap_pending,
                    bus_a.swap_overrun, bus_a.frame_count};
        return {bus_b.bank_sel, bus_b.writer_en, bus_b.swap_ack, bus_b.swap_pending,
                bus_b.swap_overrun, bus_b.frame_count};
    endfunction

    task automatic check(string name, logic [20:0] act, logic [20:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Drive one cycle of inputs, clock it, compare both DUTs with the model.
    task automatic step(logic r, logic f, logic c);
        req_v = r;
        fd_v  = f;
        clr_v = c;
        @(posedge clk);
        model_step();
        #1;
        check("model_a", dut_out(0), model_out(0));
        check("model_b", dut_out(1), model_out(1));
        req_v = 1'b0;
        fd_v  = 1'b0;
        clr_v = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_a", dut_out(0), {5'b01000, 16'h0});
        check("reset_b", dut_out(1), {5'b01000, 16'h0});
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic add(logic r, logic f, logic c, logic [4:0] e);
        vec_t v;
        v.req = r;
        v.fd  = f;
        v.clr = c;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [20:0] o;
        // Vectors for instance A (MIN_FRAMES=1, GUARD_CYCLES=4), starting from reset.
        add(0, 0, 0, 5'b01000);
        add(1, 0, 0, 5'b01010);
        add(0, 0, 0, 5'b01010);
        add(0, 1, 0, 5'b10000);  // swap: guard window begins
        add(0, 0, 0, 5'b10000);
        add(0, 0, 0, 5'b10000);
        add(1, 0, 0, 5'b10001);  // request during guard is dropped
        add(0, 0, 0, 5'b11101);  // ack
        add(0, 0, 1, 5'b11000);
        add(1, 1, 0, 5'b11010);  // simultaneous request and frame: no swap yet
        add(1, 0, 0, 5'b11011);
        add(0, 1, 0, 5'b00001);
        add(0, 0, 0, 5'b00001);
        add(0, 0, 0, 5'b00001);
        add(0, 0, 0, 5'b00001);
        add(0, 0, 1, 5'b01100);
        add(0, 0, 0, 5'b01000);
        add(1, 0, 0, 5'b01010);
        add(1, 0, 1, 5'b01011);  // new overrun beats clear
        add(0, 1, 0, 5'b10001);
        add(0, 0, 0, 5'b10001);
        add(0, 0, 0, 5'b10001);
        add(0, 0, 0, 5'b10001);
        add(0, 0, 0, 5'b11101);
        add(0, 0, 0, 5'b11001);

        // Reset held, then 100 idle cycles.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("hold_reset_a", dut_out(0), {5'b01000, 16'h0});
        check("hold_reset_b", dut_out(1), {5'b01000, 16'h0});
        reset_n = 1'b1;
        repeat (100) step(0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].fd, tbl[i].clr);
            o = dut_out(0);
            check($sformatf("vec%0d", i), {16'h0, o[20:16]}, {16'h0, tbl[i].exp});
        end

        // Minimum frames on instance B: toggles only after the third frame.
        do_reset();
        step(1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            repeat (49) step(0, 0, 0);
            step(0, 1, 0);
            o = dut_out(1);
            check($sformatf("minfr_bank%0d", i), {20'h0, o[20]}, {20'h0, (i == 3)});
        end
        o = dut_out(1);
        check("minfr_count", {5'h0, o[15:0]}, 21'd3);
        repeat (5) step(0, 0, 0);

        // Asynchronous reset in the middle of instance A's guard window.
        do_reset();
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        o = dut_out(0);
        check("midguard_reset", {18'h0, o[20:18]}, {18'h0, 3'b010});
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) step(0, 0, 0);

        // Frame counter wrap.
        do_reset();
        fd_v = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        o = dut_out(0);
        check("count_ffff", {5'h0, o[15:0]}, {5'h0, 16'hFFFF});
        @(posedge clk);
        #1;
        fd_v = 1'b0;
        o = dut_out(0);
        check("count_wrap_a", {5'h0, o[15:0]}, 21'h0);
        o = dut_out(1);
        check("count_wrap_b", {5'h0, o[15:0]}, 21'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 15) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
